// File: rtl/kp_pkg.sv
// Shared definitions for the keypad emulator: FSM states, key codes
// and the chatter LFSR step function.
package kp_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BNC_IN  = 3'd1,
        HOLD    = 3'd2,
        BNC_OUT = 3'd3,
        GAP     = 3'd4
    } kp_state_e;

    localparam int CNT_W = 16;

    // Key code = {row index, column index}; rows 1..4, columns 5..8.
    localparam logic [3:0] KEY_1   = 4'b0000;
    localparam logic [3:0] KEY_2   = 4'b0001;
    localparam logic [3:0] KEY_3   = 4'b0010;
    localparam logic [3:0] KEY_UP  = 4'b0011;
    localparam logic [3:0] KEY_4   = 4'b0100;
    localparam logic [3:0] KEY_5   = 4'b0101;
    localparam logic [3:0] KEY_6   = 4'b0110;
    localparam logic [3:0] KEY_DN  = 4'b0111;
    localparam logic [3:0] KEY_7   = 4'b1000;
    localparam logic [3:0] KEY_8   = 4'b1001;
    localparam logic [3:0] KEY_9   = 4'b1010;
    localparam logic [3:0] KEY_SEC = 4'b1011;
    localparam logic [3:0] KEY_CLR = 4'b1100;
    localparam logic [3:0] KEY_0   = 4'b1101;
    localparam logic [3:0] KEY_HEL = 4'b1110;
    localparam logic [3:0] KEY_ENT = 4'b1111;

    // Fibonacci LFSR, taps 8,6,5,4, shifting towards the MSB.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/kp_bounce_lfsr.sv
// Chatter source for the bounce phases: an 8-bit LFSR that only moves
// while enabled, exposing bit0 of the value it will hold next cycle.
module kp_bounce_lfsr
    import kp_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic       en_i,
    input  logic [7:0] seed_i,
    output logic       chatter_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = en_i ? lfsr_step(lfsr_q) : lfsr_q;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            lfsr_q <= seed_i;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // The contact register loads alongside the LFSR, so it needs the next value.
    assign chatter_o = lfsr_d[0];

endmodule

// File: rtl/kp_emulator.sv
// Keypad contact emulator: closes one row/column crosspoint of a 4x4
// matrix for a timed press with optional contact chatter on each edge.
module kp_emulator
    import kp_pkg::*;
#(
    parameter int         BOUNCE_CYC = 3,
    parameter int         HOLD_CYC   = 20,
    parameter int         GAP_CYC    = 10,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] KEY_CODE,
    input  logic       KEY_VALID,
    output logic       KEY_READY,
    input  logic [3:0] K_O,
    output logic [3:0] K_I,
    output logic       PRESSED,
    output logic       DONE
);

    localparam logic [CNT_W-1:0] BNC_LOAD  = (BOUNCE_CYC > 0) ? CNT_W'(BOUNCE_CYC - 1) : '0;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYC - 1);

    kp_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       key_q, key_d;
    logic             pressed_q, pressed_d;
    logic             last;
    logic             done;
    logic             lfsr_en;
    logic             chatter;

    assign lfsr_en = (state_q == BNC_IN) || (state_q == BNC_OUT);

    kp_bounce_lfsr u_lfsr (
        .CLK       (CLK),
        .RESET     (RESET),
        .en_i      (lfsr_en),
        .seed_i    (LFSR_SEED),
        .chatter_o (chatter)
    );

    // The counter holds the cycles remaining in the current phase; zero marks the last one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        done    = 1'b0;
        last    = (cnt_q == '0);
        unique case (state_q)
            IDLE: begin
                if (KEY_VALID) begin
                    key_d = KEY_CODE;
                    if (BOUNCE_CYC == 0) begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LOAD;
                    end else begin
                        state_d = BNC_IN;
                        cnt_d   = BNC_LOAD;
                    end
                end
            end
            BNC_IN: begin
                if (last) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (last) begin
                    if (BOUNCE_CYC == 0) begin
                        state_d = GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        state_d = BNC_OUT;
                        cnt_d   = BNC_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            BNC_OUT: begin
                if (last) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done    = RESET;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Contact level for the coming cycle; bounce phases settle on their final level.
        pressed_d = 1'b0;
        case (state_d)
            BNC_IN:  pressed_d = (cnt_d == '0) ? 1'b1 : chatter;
            HOLD:    pressed_d = 1'b1;
            BNC_OUT: pressed_d = (cnt_d == '0) ? 1'b0 : chatter;
            default: pressed_d = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            key_q     <= '0;
            pressed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            key_q     <= key_d;
            pressed_q <= pressed_d;
        end
    end

    // Only the latched column can be pulled low, and only through its own row.
    always_comb begin
        K_I             = 4'hF;
        K_I[key_q[1:0]] = ~pressed_q | K_O[key_q[3:2]];
    end

    assign KEY_READY = (state_q == IDLE);
    assign PRESSED   = pressed_q;
    assign DONE      = done;

endmodule
